// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - framebuffer RAM arbiter: scanout priority, round-robin host write/read, optional clear engine (FB_ARB_CLEAR_EN)
module fb_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 19200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              rd_rvalid,
`ifdef FB_ARB_CLEAR_EN
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {RR_WRITE, RR_READ} rr_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_SCAN, TAG_HRD} tag_t;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  rr_t  rr_last, rr_next;
  tag_t tag1, tag2;
  logic oor1, oor2;
  logic grant_scan, grant_wr, grant_rd, grant_clr;
  logic scan_in, wr_in, rd_in;

  assign scan_in = ({1'b0, scan_addr} < DEPTH_L);
  assign wr_in   = ({1'b0, wr_addr}   < DEPTH_L);
  assign rd_in   = ({1'b0, rd_addr}   < DEPTH_L);

`ifdef FB_ARB_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_BUSY} clr_state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        clr_state, clr_state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic [DATA_W-1:0] clr_color_q, clr_color_next;

  assign clr_busy = (clr_state == CLR_BUSY);

  // Clear engine state register; reset aborts any clear in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state   <= CLR_IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else begin
      clr_state   <= clr_state_next;
      clr_cnt     <= clr_cnt_next;
      clr_color_q <= clr_color_next;
    end
  end

  // Clear engine next state: one location per cycle the scanout leaves free.
  always_comb begin
    clr_state_next = clr_state;
    clr_cnt_next   = clr_cnt;
    clr_color_next = clr_color_q;
    case (clr_state)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_next = CLR_BUSY;
          clr_cnt_next   = '0;
          clr_color_next = clr_color;
        end
      end
      CLR_BUSY: begin
        if (!scan_req) begin
          if (clr_cnt == LAST_ADDR) clr_state_next = CLR_IDLE;
          else clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      default: clr_state_next = CLR_IDLE;
    endcase
  end
`endif

  // Grant decision: scanout first, then clear engine, then host round-robin.
  always_comb begin
    grant_scan = 1'b0;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    grant_clr  = 1'b0;
    rr_next    = rr_last;
    if (!rst) begin
      if (scan_req) begin
        grant_scan = 1'b1;
`ifdef FB_ARB_CLEAR_EN
      end else if (clr_busy) begin
        grant_clr = 1'b1;
`endif
      end else if (wr_valid && rd_valid) begin
        if (rr_last == RR_READ) grant_wr = 1'b1;
        else grant_rd = 1'b1;
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (rd_valid) begin
        grant_rd = 1'b1;
      end
      if (grant_wr) rr_next = RR_WRITE;
      if (grant_rd) rr_next = RR_READ;
    end
  end

  assign wr_ready = grant_wr;
  assign rd_ready = grant_rd;

  // Issue the granted op onto the RAM port and start its read tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rr_last   <= RR_READ;
      tag1      <= TAG_NONE;
      oor1      <= 1'b0;
      tag2      <= TAG_NONE;
      oor2      <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      tag1    <= TAG_NONE;
      oor1    <= 1'b0;
      rr_last <= rr_next;
      if (grant_scan) begin
        mem_addr <= scan_addr;
        tag1     <= TAG_SCAN;
        oor1     <= !scan_in;
      end else if (grant_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        mem_we    <= wr_in;
      end else if (grant_rd) begin
        mem_addr <= rd_addr;
        tag1     <= TAG_HRD;
        oor1     <= !rd_in;
`ifdef FB_ARB_CLEAR_EN
      end else if (grant_clr) begin
        mem_addr  <= clr_cnt;
        mem_wdata <= clr_color_q;
        mem_we    <= 1'b1;
`endif
      end
      tag2 <= tag1;
      oor2 <= oor1;
    end
  end

  // Route returning RAM data to its requester; out-of-range reads return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_valid <= 1'b0;
      scan_data  <= '0;
      rd_rvalid  <= 1'b0;
      rd_rdata   <= '0;
    end else begin
      scan_valid <= (tag2 == TAG_SCAN);
      rd_rvalid  <= (tag2 == TAG_HRD);
      if (tag2 == TAG_SCAN) scan_data <= oor2 ? '0 : mem_rdata;
      if (tag2 == TAG_HRD)  rd_rdata  <= oor2 ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - self-checking bench for fb_mem_arbiter
module tb_fb_mem_arbiter;
  localparam int AW = 15;
  localparam int DW = 3;
  localparam int DEPTH = 19200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic [DW-1:0] scan_data;
  logic scan_valid;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic rd_valid = 1'b0;
  logic rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_rdata;
  logic rd_rvalid;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef FB_ARB_CLEAR_EN
  logic clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic clr_busy;
`endif

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
`ifdef FB_ARB_CLEAR_EN
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
`endif
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] shadow [0:DEPTH-1];

  // Block RAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_we && mem_addr < DEPTH) ram[mem_addr] <= mem_wdata;
    mem_rdata <= (mem_addr < DEPTH) ? ram[mem_addr] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int due; logic [DW-1:0] data; } sb_t;
  sb_t scan_q[$];
  sb_t rd_q[$];
  bit exp_we[int];

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a < DEPTH) ? shadow[a] : '0;
  endfunction

  // Scoreboard: pop expected strobes as the DUT produces them
  always @(negedge clk) begin
    sb_t e;
    if (scan_valid) begin
      if (scan_q.size() == 0) chk("scan_valid_unexpected", 1, 0);
      else begin
        e = scan_q.pop_front();
        chk("scan_latency", cyc, e.due);
        chk("scan_data", scan_data, e.data);
      end
    end
    if (rd_rvalid) begin
      if (rd_q.size() == 0) chk("rd_rvalid_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_latency", cyc, e.due);
        chk("rd_rdata", rd_rdata, e.data);
      end
    end
    if (exp_we.exists(cyc)) chk("mem_we", mem_we, exp_we[cyc]);
  end

  typedef struct {
    logic s; logic [AW-1:0] sa;
    logic w; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic r; logic [AW-1:0] ra;
    logic ew; logic er;
  } vec_t;

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    scan_req = v.s; scan_addr = v.sa;
    wr_valid = v.w; wr_addr = v.wa; wr_data = v.wd;
    rd_valid = v.r; rd_addr = v.ra;
    #3;
    chk("wr_ready", wr_ready, v.ew);
    chk("rd_ready", rd_ready, v.er);
    if (v.s) scan_q.push_back('{cyc + 3, model_rd(v.sa)});
    if (v.ew && v.wa < DEPTH) shadow[v.wa] = v.wd;
    exp_we[cyc + 1] = v.ew && (v.wa < DEPTH);
    if (v.er) rd_q.push_back('{cyc + 3, model_rd(v.ra)});
  endtask

  task automatic idle(input int n);
    vec_t z;
    z = '{1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0};
    for (int i = 0; i < n; i++) apply(z);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_scan_valid"}, scan_valid, 0);
    chk({tag, "_rd_rvalid"}, rd_rvalid, 0);
    chk({tag, "_scan_data"}, scan_data, 0);
    chk({tag, "_rd_rdata"}, rd_rdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_ready"}, rd_ready, 0);
  endtask

  vec_t vecs[16];
  vec_t v;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = DW'((i * 5 + 3) % 8);
      shadow[i] = DW'((i * 5 + 3) % 8);
    end
    //          s     sa        w     wa        wd      r     ra        ew    er
    vecs[0]  = '{1'b0, 15'd0,     1'b1, 15'd5,     3'b101, 1'b0, 15'd0,     1'b1, 1'b0};
    vecs[1]  = '{1'b0, 15'd0,     1'b0, 15'd0,     3'b000, 1'b1, 15'd5,     1'b0, 1'b1};
    vecs[2]  = '{1'b1, 15'd10,    1'b1, 15'd7,     3'b001, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[3]  = '{1'b1, 15'd11,    1'b1, 15'd7,     3'b001, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[4]  = '{1'b1, 15'd12,    1'b1, 15'd7,     3'b001, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[5]  = '{1'b0, 15'd0,     1'b1, 15'd7,     3'b001, 1'b0, 15'd0,     1'b1, 1'b0};
    vecs[6]  = '{1'b0, 15'd0,     1'b1, 15'd30,    3'b110, 1'b1, 15'd30,    1'b0, 1'b1};
    vecs[7]  = '{1'b0, 15'd0,     1'b1, 15'd30,    3'b110, 1'b1, 15'd30,    1'b1, 1'b0};
    vecs[8]  = '{1'b0, 15'd0,     1'b1, 15'd31,    3'b010, 1'b1, 15'd30,    1'b0, 1'b1};
    vecs[9]  = '{1'b0, 15'd0,     1'b1, 15'd31,    3'b010, 1'b1, 15'd31,    1'b1, 1'b0};
    vecs[10] = '{1'b0, 15'd0,     1'b1, 15'd19200, 3'b111, 1'b0, 15'd0,     1'b1, 1'b0};
    vecs[11] = '{1'b0, 15'd0,     1'b0, 15'd0,     3'b000, 1'b1, 15'd19200, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 15'd19300, 1'b0, 15'd0,     3'b000, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[13] = '{1'b1, 15'd40,    1'b0, 15'd0,     3'b000, 1'b1, 15'd40,    1'b0, 1'b0};
    vecs[14] = '{1'b1, 15'd7,     1'b0, 15'd0,     3'b000, 1'b1, 15'd7,     1'b0, 1'b0};
    vecs[15] = '{1'b0, 15'd0,     1'b0, 15'd0,     3'b000, 1'b1, 15'd7,     1'b0, 1'b1};

    // Reset state, with host requests pending to prove ready is held low
    wr_valid = 1'b1; rd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);
    idle(5);
    chk("scan_q_drained", scan_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    // Host read in flight, then reset one cycle later: the read is dropped
    @(posedge clk);
    #1;
    rd_valid = 1'b1; rd_addr = 15'd5;
    #3;
    chk("abort_rd_ready", rd_ready, 1);
    @(posedge clk);
    #1;
    rd_valid = 1'b0; rst = 1'b1; wr_valid = 1'b1; wr_addr = 15'd9;
    @(posedge clk);
    #3;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0; wr_valid = 1'b0;
    idle(4);

    // Both host channels held after reset: grants alternate W,R,W,R
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, '0, 1'b1, 15'd100, DW'(i + 1), 1'b1, 15'd100, (i % 2 == 0), (i % 2 == 1)};
      apply(v);
    end
    idle(5);
    chk("scan_q_final", scan_q.size(), 0);
    chk("rd_q_final", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
